// File: rtl/sevenseg_pkg.sv
// Shared seven-segment constants: segment bit positions, digit patterns and special codes.
// Patterns are active-high abcdefg with a in bit 6 and g in bit 0.
package sevenseg_pkg;

    localparam int SEG_A = 6;
    localparam int SEG_B = 5;
    localparam int SEG_C = 4;
    localparam int SEG_D = 3;
    localparam int SEG_E = 2;
    localparam int SEG_F = 1;
    localparam int SEG_G = 0;

    localparam logic [6:0] SA = 7'(1) << SEG_A;
    localparam logic [6:0] SB = 7'(1) << SEG_B;
    localparam logic [6:0] SC = 7'(1) << SEG_C;
    localparam logic [6:0] SD = 7'(1) << SEG_D;
    localparam logic [6:0] SE = 7'(1) << SEG_E;
    localparam logic [6:0] SF = 7'(1) << SEG_F;
    localparam logic [6:0] SG = 7'(1) << SEG_G;

    localparam logic [6:0] PAT_0     = SA | SB | SC | SD | SE | SF;
    localparam logic [6:0] PAT_1     = SB | SC;
    localparam logic [6:0] PAT_2     = SA | SB | SD | SE | SG;
    localparam logic [6:0] PAT_3     = SA | SB | SC | SD | SG;
    localparam logic [6:0] PAT_4     = SB | SC | SF | SG;
    localparam logic [6:0] PAT_5     = SA | SC | SD | SF | SG;
    localparam logic [6:0] PAT_6     = SA | SC | SD | SE | SF | SG;
    localparam logic [6:0] PAT_7     = SA | SB | SC;
    localparam logic [6:0] PAT_8     = SA | SB | SC | SD | SE | SF | SG;
    localparam logic [6:0] PAT_9     = SA | SB | SC | SD | SF | SG;
    localparam logic [6:0] PAT_BLANK = 7'h00;

    localparam logic [3:0] CODE_BLANK   = 4'hE;
    localparam logic [3:0] CODE_INVALID = 4'hF;

endpackage

// File: rtl/sevenseg_pat_dec.sv
// Combinational seven-segment pattern to BCD decoder (active-high abcdefg in).
// Blank decodes to CODE_BLANK, anything unrecognised to CODE_INVALID.
module sevenseg_pat_dec
    import sevenseg_pkg::*;
(
    input  logic [6:0] pat,
    output logic [3:0] code
);

    always_comb begin
        code = CODE_INVALID;
        case (pat)
            PAT_0:     code = 4'h0;
            PAT_1:     code = 4'h1;
            PAT_2:     code = 4'h2;
            PAT_3:     code = 4'h3;
            PAT_4:     code = 4'h4;
            PAT_5:     code = 4'h5;
            PAT_6:     code = 4'h6;
            PAT_7:     code = 4'h7;
            PAT_8:     code = 4'h8;
            PAT_9:     code = 4'h9;
            PAT_BLANK: code = CODE_BLANK;
            default:   code = CODE_INVALID;
        endcase
    end

endmodule

// File: rtl/sevenseg_scan_decoder.sv
// Recovers a frame of BCD digits from a multiplexed active-low seven-segment bus.
// Optional decimal-point capture is enabled by defining SEVENSEG_DP_EN.
module sevenseg_scan_decoder
    import sevenseg_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [6:0]              seg_n,
    input  logic [NUM_DIGITS-1:0]   dig_sel_n,
`ifdef SEVENSEG_DP_EN
    input  logic                    dp_n,
    output logic [NUM_DIGITS-1:0]   frame_dp,
`endif
    output logic                    frame_valid,
    input  logic                    frame_ready,
    output logic [4*NUM_DIGITS-1:0] frame_bcd,
    output logic                    frame_err,
    output logic                    overrun
);

    // Sampled tuple layout: {dp, dig_sel, seg}, all still active-low.
    localparam int TW     = NUM_DIGITS + 8;
    localparam int SEL_LO = 7;
    localparam int SEL_HI = NUM_DIGITS + 6;
    localparam int DP_BIT = TW - 1;
    localparam logic [7:0] STABLE_MAX = 8'(STABLE_CYCLES);

    logic [TW-1:0] pin_tuple;
    logic [TW-1:0] sync1_q, sync2_q, prev_q;
    logic [7:0]    cnt_q, cnt_d;

    logic [NUM_DIGITS-1:0]      sel;
    logic                       one_sel;
    logic                       same;
    logic                       accept;
    logic [6:0]                 seg_act;
    logic [3:0]                 code;

    logic [NUM_DIGITS-1:0]      captured_q, captured_d;
    logic [NUM_DIGITS-1:0][3:0] slot_q, slot_d;
    logic [NUM_DIGITS-1:0]      slot_dp_q, slot_dp_d;

    logic                       complete, load, drop, any_invalid;
    logic                       frame_valid_d, frame_err_d, overrun_d;
    logic [4*NUM_DIGITS-1:0]    frame_bcd_d;
    logic [NUM_DIGITS-1:0]      frame_dp_q, frame_dp_d;

`ifdef SEVENSEG_DP_EN
    assign pin_tuple = {dp_n, dig_sel_n, seg_n};
    assign frame_dp  = frame_dp_q;
`else
    assign pin_tuple = {1'b1, dig_sel_n, seg_n};
`endif

    assign seg_act = ~sync2_q[6:0];

    sevenseg_pat_dec u_pat_dec (
        .pat  (seg_act),
        .code (code)
    );

    // Stability: a one-hot tuple must repeat until the counter reaches STABLE_MAX;
    // acceptance fires only on the cycle the counter first arrives there.
    always_comb begin
        sel     = ~sync2_q[SEL_HI:SEL_LO];
        one_sel = $onehot(sel);
        same    = (sync2_q == prev_q);
        cnt_d   = one_sel ? 8'd1 : 8'd0;
        if (same && one_sel) begin
            cnt_d = (cnt_q == STABLE_MAX) ? cnt_q : cnt_q + 8'd1;
        end
        accept = (cnt_d == STABLE_MAX) && (cnt_q != STABLE_MAX);
    end

    always_comb begin
        any_invalid = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (slot_q[i] == CODE_INVALID) begin
                any_invalid = 1'b1;
            end
        end
    end

    // Handshake: frame_valid/frame_bcd/frame_err/frame_dp form one beat; the beat
    // transfers on a clock edge with frame_valid && frame_ready, and the payload is
    // held unchanged while frame_valid && !frame_ready. A completed frame that
    // cannot load into a full, unconsumed output is dropped and flagged in overrun.
    always_comb begin
        complete = &captured_q;
        load     = complete && (!frame_valid || frame_ready);
        drop     = complete && !load;

        captured_d = complete ? '0 : captured_q;
        slot_d     = slot_q;
        slot_dp_d  = slot_dp_q;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (accept && sel[i]) begin
                slot_d[i]     = code;
                slot_dp_d[i]  = ~sync2_q[DP_BIT];
                captured_d[i] = 1'b1;
            end
        end

        frame_valid_d = frame_valid;
        frame_bcd_d   = frame_bcd;
        frame_err_d   = frame_err;
        frame_dp_d    = frame_dp_q;
        overrun_d     = overrun | drop;
        if (frame_valid && frame_ready) begin
            frame_valid_d = 1'b0;
        end
        if (load) begin
            frame_valid_d = 1'b1;
            frame_bcd_d   = slot_q;
            frame_err_d   = any_invalid;
            frame_dp_d    = slot_dp_q;
        end
    end

    // Synchronisers reset to the idle bus (everything inactive-high).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q     <= '1;
            sync2_q     <= '1;
            prev_q      <= '1;
            cnt_q       <= '0;
            captured_q  <= '0;
            slot_q      <= '0;
            slot_dp_q   <= '0;
            frame_valid <= 1'b0;
            frame_bcd   <= '0;
            frame_err   <= 1'b0;
            frame_dp_q  <= '0;
            overrun     <= 1'b0;
        end else begin
            sync1_q     <= pin_tuple;
            sync2_q     <= sync1_q;
            prev_q      <= sync2_q;
            cnt_q       <= cnt_d;
            captured_q  <= captured_d;
            slot_q      <= slot_d;
            slot_dp_q   <= slot_dp_d;
            frame_valid <= frame_valid_d;
            frame_bcd   <= frame_bcd_d;
            frame_err   <= frame_err_d;
            frame_dp_q  <= frame_dp_d;
            overrun     <= overrun_d;
        end
    end

endmodule

// File: tb/tb_sevenseg_scan_decoder.sv
// Self-checking bench for sevenseg_scan_decoder: directed scans plus random bus traffic
// against a run-length reference model. Define SEVENSEG_DP_EN to cover the decimal point.
`timescale 1ns/1ps
module tb_sevenseg_scan_decoder;

    localparam int N  = 4;
    localparam int ST = 8;
    localparam int TW = N + 8;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [6:0]     seg_n = '1;
    logic [N-1:0]   dig_sel_n = '1;
    logic           frame_ready = 1'b0;
    logic           frame_valid;
    logic [4*N-1:0] frame_bcd;
    logic           frame_err;
    logic           overrun;
`ifdef SEVENSEG_DP_EN
    logic           dp_n = 1'b1;
    logic [N-1:0]   frame_dp;
    logic [N-1:0]   m_dp;
    logic [N-1:0]   m_slot_dp;
    logic [N-1:0]   got_dp_q[$];
`endif

    int vectors = 0;
    int miscompares = 0;

    logic [6:0]     pat_tab [10] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33,
                                     7'h5B, 7'h5F, 7'h70, 7'h7F, 7'h7B};
    logic [4*N-1:0] got_q[$];
    logic           got_err_q[$];

    sevenseg_scan_decoder #(.NUM_DIGITS(N), .STABLE_CYCLES(ST)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .seg_n       (seg_n),
        .dig_sel_n   (dig_sel_n),
`ifdef SEVENSEG_DP_EN
        .dp_n        (dp_n),
        .frame_dp    (frame_dp),
`endif
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .frame_bcd   (frame_bcd),
        .frame_err   (frame_err),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [TW-1:0]  pipe_q[$];
    logic [TW-1:0]  last_t;
    int             run;
    logic [N-1:0]   m_cap;
    logic [3:0]     m_slot [N];
    logic           m_valid, m_err, m_ovr;
    logic [4*N-1:0] m_bcd;

    function automatic logic [3:0] model_decode(input logic [6:0] p);
        if (p == 7'h00) return 4'hE;
        for (int i = 0; i < 10; i++) begin
            if (pat_tab[i] == p) return 4'(i);
        end
        return 4'hF;
    endfunction

    function automatic logic [TW-1:0] pin_tuple();
`ifdef SEVENSEG_DP_EN
        return {dp_n, dig_sel_n, seg_n};
`else
        return {1'b1, dig_sel_n, seg_n};
`endif
    endfunction

    task automatic model_reset();
        pipe_q = {};
        pipe_q.push_back('1);
        pipe_q.push_back('1);
        last_t  = '1;
        run     = 0;
        m_cap   = '0;
        for (int i = 0; i < N; i++) m_slot[i] = 4'h0;
        m_valid = 1'b0;
        m_err   = 1'b0;
        m_ovr   = 1'b0;
        m_bcd   = '0;
`ifdef SEVENSEG_DP_EN
        m_dp      = '0;
        m_slot_dp = '0;
`endif
    endtask

    task automatic model_step();
        logic [TW-1:0] cur;
        logic [N-1:0]  sel;
        logic [3:0]    code;
        // the tuple seen by the stability check left the pins two clocks ago
        pipe_q.push_back(pin_tuple());
        cur = pipe_q.pop_front();
        sel = ~cur[N+6:7];
        if ($countones(sel) == 1) run = (cur == last_t) ? run + 1 : 1;
        else run = 0;
        last_t = cur;
        if (m_valid && frame_ready) m_valid = 1'b0;
        if (&m_cap) begin
            if (!m_valid) begin
                m_valid = 1'b1;
                m_err   = 1'b0;
                for (int i = 0; i < N; i++) begin
                    m_bcd[4*i +: 4] = m_slot[i];
                    if (m_slot[i] == 4'hF) m_err = 1'b1;
                end
`ifdef SEVENSEG_DP_EN
                m_dp = m_slot_dp;
`endif
            end else begin
                m_ovr = 1'b1;
            end
            m_cap = '0;
        end
        if (run == ST) begin
            code = model_decode(~cur[6:0]);
            for (int i = 0; i < N; i++) begin
                if (sel[i]) begin
                    m_slot[i] = code;
                    m_cap[i]  = 1'b1;
`ifdef SEVENSEG_DP_EN
                    m_slot_dp[i] = ~cur[TW-1];
`endif
                end
            end
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else model_step();
        end
    end

    // ---------------- compare + frame monitor ----------------
    initial begin
        forever begin
            @(negedge clk);
            check("outputs", 64'({frame_valid, frame_err, overrun, frame_bcd}),
                  64'({m_valid, m_err, m_ovr, m_bcd}));
`ifdef SEVENSEG_DP_EN
            check("frame_dp", 64'(frame_dp), 64'(m_dp));
`endif
            if (frame_valid && frame_ready) begin
                got_q.push_back(frame_bcd);
                got_err_q.push_back(frame_err);
`ifdef SEVENSEG_DP_EN
                got_dp_q.push_back(frame_dp);
`endif
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic show(input int pos, input logic [6:0] pat, input int hold);
        logic [N-1:0] s;
        s = '0;
        s[pos] = 1'b1;
        dig_sel_n = ~s;
        seg_n = ~pat;
        tick(hold);
    endtask

    task automatic idle(input int n);
        dig_sel_n = '1;
        seg_n = '1;
        tick(n);
    endtask

    task automatic scan(input logic [6:0] p0, input logic [6:0] p1,
                        input logic [6:0] p2, input logic [6:0] p3);
        show(0, p0, 12);
        show(1, p1, 12);
        show(2, p2, 12);
        show(3, p3, 12);
    endtask

    task automatic expect_frame(input string name, input int idx,
                                input logic [4*N-1:0] bcd, input logic err);
        if (got_q.size() > idx) begin
            check({name, "_bcd"}, 64'(got_q[idx]), 64'(bcd));
            check({name, "_err"}, 64'(got_err_q[idx]), 64'(err));
        end else begin
            check({name, "_present"}, 64'(got_q.size()), 64'(idx + 1));
        end
    endtask

    task automatic clear_got();
        got_q.delete();
        got_err_q.delete();
`ifdef SEVENSEG_DP_EN
        got_dp_q.delete();
`endif
    endtask

    initial begin
        tick(3);
        check("rst_valid", 64'(frame_valid), 64'(0));
        check("rst_bcd", 64'(frame_bcd), 64'(0));
        check("rst_err", 64'(frame_err), 64'(0));
        check("rst_overrun", 64'(overrun), 64'(0));
        rst_n = 1'b1;
        idle(4);

        // basic frame 1,2,3,4
        frame_ready = 1'b1;
        clear_got();
        scan(pat_tab[1], pat_tab[2], pat_tab[3], pat_tab[4]);
        idle(6);
        check("s1_count", 64'(got_q.size()), 64'(1));
        expect_frame("s1", 0, 16'h4321, 1'b0);

        // a 7-cycle dwell is not accepted
        clear_got();
        show(0, pat_tab[5], 7);
        show(1, pat_tab[6], 12);
        show(2, pat_tab[7], 12);
        show(3, pat_tab[8], 12);
        idle(6);
        check("s2_short_dwell", 64'(got_q.size()), 64'(0));
        show(0, pat_tab[9], 12);
        idle(6);
        expect_frame("s2", 0, 16'h8769, 1'b0);

        // invalid and blank patterns
        clear_got();
        scan(pat_tab[5], pat_tab[6], 7'h01, pat_tab[7]);
        idle(6);
        scan(pat_tab[5], pat_tab[6], 7'h00, pat_tab[7]);
        idle(6);
        expect_frame("s3_inv", 0, 16'h7F65, 1'b1);
        expect_frame("s3_blank", 1, 16'h7E65, 1'b0);

        // back-pressure: second frame dropped
        frame_ready = 1'b0;
        clear_got();
        scan(pat_tab[8], pat_tab[9], pat_tab[0], pat_tab[1]);
        scan(pat_tab[2], pat_tab[3], pat_tab[4], pat_tab[5]);
        idle(6);
        check("s4_valid_held", 64'(frame_valid), 64'(1));
        check("s4_bcd_held", 64'(frame_bcd), 64'(16'h1098));
        check("s4_overrun", 64'(overrun), 64'(1));
        frame_ready = 1'b1;
        tick(2);
        check("s4_consumed", 64'(frame_valid), 64'(0));
        check("s4_overrun_sticky", 64'(overrun), 64'(1));

        // multiple selects ignored, then reset mid-frame
        clear_got();
        dig_sel_n = ~4'b0011;
        seg_n = ~pat_tab[3];
        tick(20);
        show(2, pat_tab[4], 12);
        show(3, pat_tab[5], 12);
        idle(6);
        check("s5_multi_sel", 64'(got_q.size()), 64'(0));
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("s5_async_rst", 64'({frame_valid, frame_err, overrun, frame_bcd}), 64'(0));
        tick(2);
        rst_n = 1'b1;
        show(0, pat_tab[6], 12);
        show(1, pat_tab[7], 12);
        idle(6);
        check("s5_partial_discarded", 64'(got_q.size()), 64'(0));
        show(2, pat_tab[8], 12);
        show(3, pat_tab[9], 12);
        idle(6);
        expect_frame("s5_clean", 0, 16'h9876, 1'b0);

`ifdef SEVENSEG_DP_EN
        clear_got();
        for (int p = 0; p < N; p++) begin
            dp_n = (p == 1) ? 1'b0 : 1'b1;
            show(p, pat_tab[p], 12);
        end
        dp_n = 1'b1;
        idle(6);
        if (got_dp_q.size() > 0) check("dp_frame", 64'(got_dp_q[0]), 64'(4'b0010));
        else check("dp_present", 64'(got_dp_q.size()), 64'(1));
`endif

        // random traffic against the model
        for (int k = 0; k < 80; k++) begin
            int r;
            logic [6:0] pat;
            r = $urandom_range(0, 11);
            if (r < 10) pat = pat_tab[r];
            else if (r == 10) pat = 7'h00;
            else pat = 7'($urandom);
            frame_ready = 1'($urandom_range(0, 1));
`ifdef SEVENSEG_DP_EN
            dp_n = 1'($urandom_range(0, 1));
`endif
            if ($urandom_range(0, 9) == 0) begin
                dig_sel_n = 4'($urandom);
                seg_n = ~pat;
                tick($urandom_range(5, 14));
            end else begin
                show($urandom_range(0, N - 1), pat, $urandom_range(5, 14));
            end
        end
        frame_ready = 1'b1;
        idle(10);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
